// File: rtl/riscv151_pkg.sv
// Shared types and constants for the Riscv151 hazard and forwarding logic.
package riscv151_pkg;

  localparam int REG_AW        = 5;
  localparam int FWD_RF        = 0;
  localparam int FWD_SLOT_BASE = 1;

  // One in-flight instruction tracked after the issue point.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wb_en;
    logic              is_load;
  } slot_t;

endpackage

// File: rtl/hazard_fwd_match.sv
// Priority matcher for one source register over the in-flight slots.
// The youngest (lowest-index) matching writer wins.
module hazard_fwd_match
  import riscv151_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  slot_t [DEPTH-1:0] slots,
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_used,
  output logic [SEL_W-1:0]  sel,
  output logic              load_pending
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path can infer a latch.
    sel          = SEL_W'(FWD_RF);
    load_pending = 1'b0;
    // Scan oldest to youngest so the youngest match is the last one written.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (slots[k].valid && slots[k].wb_en && (slots[k].rd == rs) &&
          (rs != '0) && rs_used) begin
        sel          = SEL_W'(FWD_SLOT_BASE + k);
        load_pending = slots[k].is_load && (k < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: in-flight writer scoreboard, forward selects,
// load-use stall, flush bubbles and memory-busy freeze. Optional HAZARD_PERF_EN adds perf counters.
module pipe_hazard_ctrl
  import riscv151_pkg::slot_t;
#(
  parameter int DEPTH    = 2,
  // Must match riscv151_pkg::REG_AW, which sizes the slot record.
  parameter int REG_AW   = riscv151_pkg::REG_AW,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic [REG_AW-1:0] issue_rs2,
  input  logic              issue_rs1_used,
  input  logic              issue_rs2_used,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              issue_wb_en,
  input  logic              issue_is_load,
  input  logic              flush_req,
  input  logic              mem_busy,
  output logic [SEL_W-1:0]  fwd_a_sel,
  output logic [SEL_W-1:0]  fwd_b_sel,
  output logic              stall,
  output logic              flush,
  output logic              freeze
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  slot_t [DEPTH-1:0] slots_q;
  slot_t             slot0_d;
  logic [SEL_W-1:0]  sel_a, sel_b;
  logic              pend_a, pend_b;
  logic              load_use;

  hazard_fwd_match #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)) u_match_a (
    .slots       (slots_q),
    .rs          (issue_rs1),
    .rs_used     (issue_rs1_used),
    .sel         (sel_a),
    .load_pending(pend_a)
  );

  hazard_fwd_match #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)) u_match_b (
    .slots       (slots_q),
    .rs          (issue_rs2),
    .rs_used     (issue_rs2_used),
    .sel         (sel_b),
    .load_pending(pend_b)
  );

  assign load_use = issue_valid && (pend_a || pend_b);

  // Priority: freeze, then flush, then load-use stall; everything is held at 0 in reset.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    freeze    = 1'b0;
    flush     = 1'b0;
    stall     = 1'b0;
    if (rst) begin
      fwd_a_sel = sel_a;
      fwd_b_sel = sel_b;
      freeze    = mem_busy;
      flush     = !mem_busy && flush_req;
      stall     = !mem_busy && !flush_req && load_use;
    end
  end

  // A killed, stalled or absent instruction enters as a bubble.
  always_comb begin
    slot0_d = '0;
    if (issue_valid && !flush_req && !load_use) begin
      slot0_d.valid   = 1'b1;
      slot0_d.rd      = issue_rd;
      slot0_d.wb_en   = issue_wb_en;
      slot0_d.is_load = issue_is_load;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the whole slot record is cleared, not just valid, so stale rd/flags never resurface.
      slots_q <= '0;
    end else if (!mem_busy) begin
      // NOTE: non-blocking assignments let every slot read its neighbour's old value in one shift.
      slots_q[0] <= slot0_d;
      for (int k = 1; k < DEPTH; k++) begin
        slots_q[k] <= slots_q[k-1];
      end
    end
  end

`ifdef HAZARD_PERF_EN
  // stall and flush are already zero while frozen, so freeze cycles are never counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (LOAD_LAT=1 and 2, DEPTH=3) share
// directed stimulus; an age-list model predicts outputs every cycle.
module tb_pipe_hazard_ctrl;

  localparam int DEPTH = 3;
  localparam int SEL_W = 2;
  localparam int NI    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       issue_valid = 1'b0;
  logic [4:0] issue_rs1 = '0, issue_rs2 = '0, issue_rd = '0;
  logic       issue_rs1_used = 1'b1, issue_rs2_used = 1'b1;
  logic       issue_wb_en = 1'b0, issue_is_load = 1'b0;
  logic       flush_req = 1'b0, mem_busy = 1'b0;

  logic [NI-1:0][SEL_W-1:0] fwd_a_sel, fwd_b_sel;
  logic [NI-1:0]            stall, flush, freeze;
`ifdef HAZARD_PERF_EN
  logic [NI-1:0][31:0]      perf_stall_cnt, perf_flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DEPTH(DEPTH), .REG_AW(5), .LOAD_LAT(1), .SEL_W(SEL_W)) u_dut_a (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_wb_en(issue_wb_en), .issue_is_load(issue_is_load),
    .flush_req(flush_req), .mem_busy(mem_busy),
    .fwd_a_sel(fwd_a_sel[0]), .fwd_b_sel(fwd_b_sel[0]),
    .stall(stall[0]), .flush(flush[0]), .freeze(freeze[0])
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt[0]), .perf_flush_cnt(perf_flush_cnt[0])
`endif
  );

  pipe_hazard_ctrl #(.DEPTH(DEPTH), .REG_AW(5), .LOAD_LAT(2), .SEL_W(SEL_W)) u_dut_b (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_wb_en(issue_wb_en), .issue_is_load(issue_is_load),
    .flush_req(flush_req), .mem_busy(mem_busy),
    .fwd_a_sel(fwd_a_sel[1]), .fwd_b_sel(fwd_b_sel[1]),
    .stall(stall[1]), .flush(flush[1]), .freeze(freeze[1])
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt[1]), .perf_flush_cnt(perf_flush_cnt[1])
`endif
  );

  // Model: per instance, age-ordered list of registers still to be written (-1 = none).
  int m_dst [NI][DEPTH];
  bit m_ld  [NI][DEPTH];
  int m_stalls  [NI];
  int m_flushes [NI];

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_stalls[i]  = 0;
      m_flushes[i] = 0;
      for (int a = 0; a < DEPTH; a++) begin
        m_dst[i][a] = -1;
        m_ld[i][a]  = 1'b0;
      end
    end
  end

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int youngest_writer(int i, int rs, bit used);
    if (!used || rs == 0) return -1;
    for (int a = 0; a < DEPTH; a++)
      if (m_dst[i][a] == rs) return a;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare process: checks both instances mid-cycle, then advances the model.
  always @(negedge clk) begin
    #2;
    cyc++;
    for (int i = 0; i < NI; i++) begin
      int ka, kb, e_sa, e_sb;
      bit lu, e_st, e_fl, e_fz;
      string tag;
      tag = $sformatf("c%0d dut%0d", cyc, i);
      ka = youngest_writer(i, int'(issue_rs1), issue_rs1_used);
      kb = youngest_writer(i, int'(issue_rs2), issue_rs2_used);
      lu = issue_valid && ((ka >= 0 && m_ld[i][ka] && ka < lat_of(i)) ||
                           (kb >= 0 && m_ld[i][kb] && kb < lat_of(i)));
      e_sa = 0; e_sb = 0; e_st = 0; e_fl = 0; e_fz = 0;
      if (rst) begin
        e_sa = ka + 1;
        e_sb = kb + 1;
        e_fz = mem_busy;
        e_fl = !mem_busy && flush_req;
        e_st = !mem_busy && !flush_req && lu;
      end
      check({tag, " fwd_a_sel"}, 32'(fwd_a_sel[i]), 32'(e_sa));
      check({tag, " fwd_b_sel"}, 32'(fwd_b_sel[i]), 32'(e_sb));
      check({tag, " stall"},  32'(stall[i]),  32'(e_st));
      check({tag, " flush"},  32'(flush[i]),  32'(e_fl));
      check({tag, " freeze"}, 32'(freeze[i]), 32'(e_fz));
`ifdef HAZARD_PERF_EN
      check({tag, " perf_stall_cnt"}, perf_stall_cnt[i], 32'(m_stalls[i]));
      check({tag, " perf_flush_cnt"}, perf_flush_cnt[i], 32'(m_flushes[i]));
`endif
      if (!rst) begin
        for (int a = 0; a < DEPTH; a++) begin
          m_dst[i][a] = -1;
          m_ld[i][a]  = 1'b0;
        end
        m_stalls[i]  = 0;
        m_flushes[i] = 0;
      end else if (!mem_busy) begin
        if (e_st) m_stalls[i]++;
        if (e_fl) m_flushes[i]++;
        for (int a = DEPTH - 1; a > 0; a--) begin
          m_dst[i][a] = m_dst[i][a-1];
          m_ld[i][a]  = m_ld[i][a-1];
        end
        m_dst[i][0] = (issue_valid && issue_wb_en && !flush_req && !lu) ? int'(issue_rd) : -1;
        m_ld[i][0]  = issue_is_load;
      end
    end
  end

  // One issue-point cycle; inputs change on the falling edge.
  task automatic step(input bit v, input int r1, input int r2, input int rd,
                      input bit wb, input bit ld, input bit fl = 1'b0,
                      input bit mb = 1'b0, input bit rn = 1'b1);
    @(negedge clk);
    rst           = rn;
    issue_valid   = v;
    issue_rs1     = 5'(r1);
    issue_rs2     = 5'(r2);
    issue_rd      = 5'(rd);
    issue_wb_en   = wb;
    issue_is_load = ld;
    flush_req     = fl;
    mem_busy      = mb;
    #3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a live issue, flush_req and mem_busy: everything must read 0.
    step(1, 5, 5, 5, 1, 0, 1, 1, 0);
    check("rst freeze", 32'(freeze[0]), 0);
    check("rst flush",  32'(flush[0]),  0);
    check("rst stall",  32'(stall[0]),  0);
    check("rst fwd_a",  32'(fwd_a_sel[0]), 0);

    step(1, 1, 2, 5, 1, 0);                      // c1 add x5
    step(1, 5, 0, 6, 1, 0);                      // c2 add x6,x5
    check("c2 fwd_a", 32'(fwd_a_sel[0]), 1);
    check("c2 fwd_b", 32'(fwd_b_sel[0]), 0);
    step(1, 0, 0, 5, 1, 0);                      // c3 add x5 again
    step(1, 5, 6, 9, 1, 0);                      // c4 x5 in slot0 and slot2
    check("c4 youngest fwd_a", 32'(fwd_a_sel[0]), 1);
    check("c4 fwd_b",          32'(fwd_b_sel[0]), 2);
    step(1, 5, 0, 0, 1, 0);                      // c5 x5 only in slot1; writes x0
    check("c5 fwd_a", 32'(fwd_a_sel[0]), 2);
    issue_rs2_used = 1'b0;
    step(1, 0, 9, 10, 1, 0);                     // c6 read x0, rs2 unused
    check("c6 x0 fwd_a",     32'(fwd_a_sel[0]), 0);
    check("c6 unused fwd_b", 32'(fwd_b_sel[0]), 0);
    issue_rs2_used = 1'b1;

    step(1, 0, 0, 7, 1, 1);                      // c7 lw x7
    step(1, 7, 7, 8, 1, 0);                      // c8 add x8,x7,x7
    check("c8 stall lat1", 32'(stall[0]), 1);
    check("c8 stall lat2", 32'(stall[1]), 1);
    step(1, 7, 7, 8, 1, 0);                      // c9 held
    check("c9 stall lat1", 32'(stall[0]), 0);
    check("c9 fwd_a lat1", 32'(fwd_a_sel[0]), 2);
    check("c9 fwd_b lat1", 32'(fwd_b_sel[0]), 2);
    check("c9 stall lat2", 32'(stall[1]), 1);
    step(1, 7, 7, 8, 1, 0);                      // c10 held
    check("c10 stall lat2", 32'(stall[1]), 0);
    check("c10 fwd_a lat2", 32'(fwd_a_sel[1]), 3);

    step(1, 0, 0, 11, 1, 1);                     // c11 lw x11
    step(1, 11, 11, 12, 1, 0, 1);                // c12 load-use + flush
    check("c12 flush", 32'(flush[0]), 1);
    check("c12 stall", 32'(stall[0]), 0);
    step(1, 12, 0, 13, 1, 0);                    // c13 read killed x12
    check("c13 killed fwd_a", 32'(fwd_a_sel[0]), 0);
    step(0, 0, 0, 0, 0, 0, 1);                   // c14 flush bubble
    check("c14 flush", 32'(flush[0]), 1);

    step(1, 13, 0, 14, 1, 0, 0, 1);              // c15 frozen
    check("c15 freeze", 32'(freeze[0]), 1);
    check("c15 stall",  32'(stall[0]),  0);
    check("c15 fwd_a",  32'(fwd_a_sel[0]), 2);
    step(1, 13, 0, 14, 1, 0, 1, 1);              // c16 flush_req ignored
    check("c16 flush ignored", 32'(flush[0]), 0);
    step(1, 13, 0, 14, 1, 0, 0, 1);              // c17
    step(1, 13, 0, 14, 1, 0);                    // c18 released
    check("c18 fwd_a", 32'(fwd_a_sel[0]), 2);
    check("c18 freeze", 32'(freeze[0]), 0);

    step(1, 0, 0, 20, 1, 1);                     // c19 lw x20
    step(1, 0, 20, 21, 1, 0);                    // c20 stall
    step(1, 0, 20, 21, 1, 0);                    // c21
    step(1, 0, 0, 22, 1, 1);                     // c22 lw x22
    step(1, 22, 22, 23, 1, 0);                   // c23 stall
    step(1, 22, 22, 23, 1, 0);                   // c24
    step(1, 0, 0, 25, 1, 1);                     // c25 lw x25
    step(0, 25, 0, 0, 0, 0);                     // c26 invalid reader
    check("c26 invalid no stall", 32'(stall[0]), 0);
    check("c26 fwd_a",            32'(fwd_a_sel[0]), 1);
    step(1, 0, 0, 27, 1, 1);                     // c27 lw x27
    step(1, 27, 0, 28, 1, 0);                    // c28 stall
    step(1, 27, 0, 28, 1, 0);                    // c29
`ifdef HAZARD_PERF_EN
    check("c29 perf_stall_cnt", perf_stall_cnt[0], 4);
    check("c29 perf_flush_cnt", perf_flush_cnt[0], 2);
`endif

    step(1, 0, 0, 1, 1, 0);                      // c30..c32 fill all slots
    step(1, 0, 0, 2, 1, 0);
    step(1, 0, 0, 3, 1, 0);
    step(1, 3, 2, 0, 0, 0, 0, 0, 0);             // c33 reset mid-operation
    check("c33 rst fwd_a", 32'(fwd_a_sel[0]), 0);
    check("c33 rst fwd_b", 32'(fwd_b_sel[0]), 0);
    step(1, 3, 2, 0, 0, 0);                      // c34 after reset
    check("c34 fwd_a", 32'(fwd_a_sel[0]), 0);
    check("c34 fwd_b", 32'(fwd_b_sel[0]), 0);
`ifdef HAZARD_PERF_EN
    check("c34 perf_stall_cnt", perf_stall_cnt[0], 0);
`endif
    step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
